// File: rtl/data_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : data_tx_pkg                                                       |
// | Brief  : Shared types and constants for the SPI register-read transmit     |
// |          path: command codes, serializer state encoding and the FIFO entry.|
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package data_tx_pkg;

    // SPI command opcodes understood by the slave front end
    localparam logic [7:0] c_CMD_WR_REG    = 8'h02;
    localparam logic [7:0] c_CMD_RD_STATUS = 8'h05;
    localparam logic [7:0] c_CMD_RD_REG    = 8'h0B;

    localparam int c_ADDR_W     = 4;
    // Widest register word the transmit path supports; narrower words occupy
    // the low bits of the entry and the upper bits stay zero.
    localparam int c_MAX_WORD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [c_ADDR_W-1:0]     addr;
        logic [c_MAX_WORD_W-1:0] data;
    } tx_entry_t;

endpackage
`default_nettype wire

// File: rtl/data_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : word_fifo                                                         |
// | Brief  : Synchronous FIFO of {addr, data} entries between register capture |
// |          and the byte serializer.                                          |
// | Ports  : clk_i, rst_i   - clock / synchronous active-high reset            |
// |          flush_i        - empty the FIFO next cycle                        |
// |          push_i, din_i  - write request and entry                          |
// |          pop_i, dout_o  - read request and head entry (show-ahead)         |
// |          full_o, empty_o- occupancy flags                                  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module word_fifo
    import data_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      push_i,
    input  tx_entry_t din_i,
    input  logic      pop_i,
    output tx_entry_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_PTR_W1 = c_PTR_W + 1;
    localparam logic [c_PTR_W:0] c_PTR_ONE = c_PTR_W1'(1);

    // The extra MSB is a wrap bit: equal indices with differing wrap bits
    // means full, identical pointers means empty.
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    tx_entry_t        r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO still lands when it coincides with a pop.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    assign dout_o = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : data_tx                                                           |
// | Brief  : Captures register read data, buffers it in a word FIFO and       |
// |          serializes each word MSB-first onto a byte-wide SPI handshake.    |
// | Ports  : clk_i, rst_i        - clock / synchronous active-high reset       |
// |          abort_i             - CS deasserted; flush everything pending     |
// |          reg_rd_en_i/addr_i  - register read strobe and address            |
// |          reg_rd_data_i       - read data, valid one cycle after strobe     |
// |          spi_byte_rdy_i      - SPI core takes the presented byte           |
// |          spi_byte_vld_o/data_o/addr_o - presented byte and its word addr   |
// |          ovf_o               - sticky: a word was dropped, FIFO full       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module data_tx
    import data_tx_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              abort_i,
    input  logic              reg_rd_en_i,
    input  logic [3:0]        reg_rd_addr_i,
    input  logic [WORD_W-1:0] reg_rd_data_i,
    input  logic              spi_byte_rdy_i,
    output logic              spi_byte_vld_o,
    output logic [7:0]        spi_byte_data_o,
    output logic [3:0]        spi_byte_addr_o,
    output logic              ovf_o
);

    localparam int c_NBYTES = WORD_W / 8;
    localparam int c_CNT_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(c_NBYTES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Capture pipeline: the strobe is registered so the push lines up with
    // the read data arriving one cycle later.
    logic       r_cap_vld;
    logic [3:0] r_cap_addr;

    tx_state_e         r_state;
    logic [WORD_W-1:0] r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_vld;
    logic [3:0]        r_addr;
    logic              r_ovf;

    tx_entry_t w_push_entry;
    tx_entry_t w_pop_entry;
    logic      w_push;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_drop;
    logic      w_work_pending;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cap_vld  <= 1'b0;
            r_cap_addr <= '0;
        end else begin
            // A strobe coincident with abort belongs to the dead transaction.
            r_cap_vld  <= reg_rd_en_i & ~abort_i;
            r_cap_addr <= reg_rd_addr_i;
        end
    end

    always_comb begin
        w_push_entry                    = '0;
        w_push_entry.addr               = r_cap_addr;
        w_push_entry.data[WORD_W-1:0]   = reg_rd_data_i;
    end

    assign w_push = r_cap_vld & ~abort_i;
    assign w_pop  = (r_state == ST_LOAD) & ~abort_i;
    assign w_drop = w_push & w_full & ~w_pop;

    // Counting the in-flight push lets IDLE leave one cycle early, which is
    // what brings first-byte latency down to three cycles after the strobe.
    assign w_work_pending = ~w_empty | w_push;

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (abort_i),
        .push_i  (w_push),
        .din_i   (w_push_entry),
        .pop_i   (w_pop),
        .dout_o  (w_pop_entry),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    if (WORD_W < c_MAX_WORD_W) begin : g_unused_hi
        logic w_unused_data_hi;
        assign w_unused_data_hi = ^w_pop_entry.data[c_MAX_WORD_W-1:WORD_W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
        end else if (abort_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_work_pending) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_shift <= w_pop_entry.data[WORD_W-1:0];
                    r_addr  <= w_pop_entry.addr;
                    r_cnt   <= '0;
                    r_vld   <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    // Shift only on transfer so data/addr hold under backpressure.
                    if (spi_byte_rdy_i) begin
                        if (r_cnt == c_LAST_BYTE) begin
                            r_vld   <= 1'b0;
                            r_state <= w_work_pending ? ST_LOAD : ST_IDLE;
                        end else begin
                            r_shift <= r_shift << 8;
                            r_cnt   <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign spi_byte_vld_o  = r_vld;
    assign spi_byte_data_o = r_shift[WORD_W-1 -: 8];
    assign spi_byte_addr_o = r_addr;
    assign ovf_o           = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_data_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_data_tx                                                        |
// | Brief  : Directed self-checking bench for data_tx with a queue-based       |
// |          reference model compared every cycle.                             |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_data_tx;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int NB     = WORD_W / 8;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              abort_i = 1'b0;
    logic              reg_rd_en_i = 1'b0;
    logic [3:0]        reg_rd_addr_i = '0;
    logic [WORD_W-1:0] reg_rd_data_i = '0;
    logic              spi_byte_rdy_i = 1'b0;
    logic              spi_byte_vld_o;
    logic [7:0]        spi_byte_data_o;
    logic [3:0]        spi_byte_addr_o;
    logic              ovf_o;

    always #5 clk = ~clk;

    data_tx #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .abort_i         (abort_i),
        .reg_rd_en_i     (reg_rd_en_i),
        .reg_rd_addr_i   (reg_rd_addr_i),
        .reg_rd_data_i   (reg_rd_data_i),
        .spi_byte_rdy_i  (spi_byte_rdy_i),
        .spi_byte_vld_o  (spi_byte_vld_o),
        .spi_byte_data_o (spi_byte_data_o),
        .spi_byte_addr_o (spi_byte_addr_o),
        .ovf_o           (ovf_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words waiting, bytes of the word in service, and a phase:
    // 0 = nothing to do, 1 = fetching next word (bubble), 2 = presenting bytes.
    logic [35:0] m_fifo [$];
    logic [7:0]  m_bytes [$];
    logic [3:0]  m_cur_addr = '0;
    int          m_phase = 0;
    bit          m_ovf = 1'b0;
    bit          m_cap = 1'b0;
    logic [3:0]  m_cap_addr = '0;

    initial begin
        int          n;
        bit          push;
        bit          popped;
        logic [35:0] e;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                m_fifo.delete();
                m_bytes.delete();
                m_phase    = 0;
                m_ovf      = 1'b0;
                m_cap      = 1'b0;
                m_cur_addr = '0;
            end else if (abort_i) begin
                m_fifo.delete();
                m_bytes.delete();
                m_phase = 0;
                m_cap   = 1'b0;
            end else begin
                n      = m_fifo.size();
                push   = m_cap;
                popped = 1'b0;
                case (m_phase)
                    0: if (n > 0 || push) m_phase = 1;
                    1: begin
                        e = m_fifo.pop_front();
                        popped = 1'b1;
                        m_cur_addr = e[35:32];
                        m_bytes.delete();
                        for (int b = 0; b < NB; b++) m_bytes.push_back(e[31-8*b -: 8]);
                        m_phase = 2;
                    end
                    default: if (spi_byte_rdy_i) begin
                        void'(m_bytes.pop_front());
                        if (m_bytes.size() == 0) m_phase = (n > 0 || push) ? 1 : 0;
                    end
                endcase
                if (push) begin
                    if (n < DEPTH || popped) m_fifo.push_back({m_cap_addr, reg_rd_data_i});
                    else m_ovf = 1'b1;
                end
                m_cap      = reg_rd_en_i;
                m_cap_addr = reg_rd_addr_i;
            end
        end
    end

    // ---------------- per-cycle compare + transfer log ----------------
    logic [7:0] got_b [$];
    logic [3:0] got_a [$];

    initial begin
        forever begin
            @(negedge clk);
            chk("vld", spi_byte_vld_o, (m_phase == 2));
            chk("ovf", ovf_o, m_ovf);
            if (m_phase == 2 && spi_byte_vld_o === 1'b1) begin
                chk("data", spi_byte_data_o, m_bytes[0]);
                chk("addr", spi_byte_addr_o, m_cur_addr);
            end
            if (spi_byte_vld_o === 1'b1 && spi_byte_rdy_i) begin
                got_b.push_back(spi_byte_data_o);
                got_a.push_back(spi_byte_addr_o);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] a, input logic [31:0] d);
        reg_rd_en_i   = 1'b1;
        reg_rd_addr_i = a;
        tick();
        reg_rd_en_i   = 1'b0;
        reg_rd_data_i = d;
        tick();
    endtask

    task automatic wait_vld(input int budget);
        for (int i = 0; i < budget && spi_byte_vld_o !== 1'b1; i++) tick();
        chk("wait_vld", spi_byte_vld_o, 1);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        for (int i = 0; i < budget && got_b.size() < n; i++) tick();
        chk("xfer_count", got_b.size(), n);
    endtask

    task automatic clear_log();
        got_b.delete();
        got_a.delete();
    endtask

    function automatic logic [31:0] dovf(input int k);
        return 32'h10111213 + 32'(k) * 32'h10101010;
    endfunction

    function automatic logic [31:0] dfill(input int k);
        return 32'hC0C0C0C0 + 32'(k) * 32'h01010101;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        // ---- reset state ----
        tick();
        tick();
        chk("rst_vld", spi_byte_vld_o, 0);
        chk("rst_data", spi_byte_data_o, 8'h00);
        chk("rst_addr", spi_byte_addr_o, 4'h0);
        chk("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        tick();

        // ---- single read, latency 3 ----
        clear_log();
        spi_byte_rdy_i = 1'b1;
        strobe(4'h3, 32'h11223344);
        chk("lat_n2_vld", spi_byte_vld_o, 0);
        tick();
        chk("lat_n3_vld", spi_byte_vld_o, 1);
        chk("lat_n3_data", spi_byte_data_o, 8'h11);
        wait_xfers(4, 20);
        chk("single_b0", got_b[0], 8'h11);
        chk("single_b1", got_b[1], 8'h22);
        chk("single_b2", got_b[2], 8'h33);
        chk("single_b3", got_b[3], 8'h44);
        chk("single_addr", got_a[3], 4'h3);
        repeat (4) tick();

        // ---- backpressure ----
        clear_log();
        spi_byte_rdy_i = 1'b0;
        strobe(4'h5, 32'hAABBCCDD);
        wait_vld(10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", spi_byte_data_o, 8'hAA);
            chk("bp_hold_addr", spi_byte_addr_o, 4'h5);
            tick();
        end
        spi_byte_rdy_i = 1'b1;
        wait_xfers(4, 20);
        chk("bp_b0", got_b[0], 8'hAA);
        chk("bp_b1", got_b[1], 8'hBB);
        chk("bp_b3", got_b[3], 8'hDD);
        repeat (4) tick();

        // ---- abort mid-word with a second word queued ----
        clear_log();
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'h7;
        tick();
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'h8; reg_rd_data_i = 32'hDEADBEEF;
        tick();
        reg_rd_en_i = 1'b0; reg_rd_data_i = 32'h55667788;
        wait_xfers(2, 20);
        spi_byte_rdy_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_vld", spi_byte_vld_o, 0);
        spi_byte_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_idle_vld", spi_byte_vld_o, 0);
        end
        chk("abort_count", got_b.size(), 2);
        chk("abort_b0", got_b[0], 8'hDE);
        chk("abort_b1", got_b[1], 8'hAD);
        // strobe coincident with abort is discarded
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'h4; abort_i = 1'b1;
        tick();
        reg_rd_en_i = 1'b0; abort_i = 1'b0; reg_rd_data_i = 32'h99999999;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_rd_vld", spi_byte_vld_o, 0);
        end
        clear_log();
        strobe(4'h2, 32'h01020304);
        wait_xfers(4, 20);
        chk("post_abort_b0", got_b[0], 8'h01);
        chk("post_abort_b3", got_b[3], 8'h04);
        chk("post_abort_addr", got_a[0], 4'h2);
        repeat (4) tick();

        // ---- full FIFO with coincident push and pop ----
        clear_log();
        spi_byte_rdy_i = 1'b0;
        strobe(4'hA, 32'h0A0B0C0D);
        wait_vld(10);
        for (int j = 0; j <= 4; j++) begin
            reg_rd_en_i   = (j < 4);
            reg_rd_addr_i = 4'(11 + j);
            reg_rd_data_i = (j > 0) ? dfill(j - 1) : 32'h0;
            tick();
        end
        tick();
        chk("full_ovf_pre", ovf_o, 0);
        spi_byte_rdy_i = 1'b1;
        tick();
        tick();
        tick();
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'hF;
        tick();
        reg_rd_en_i = 1'b0; reg_rd_data_i = 32'h5A5B5C5D;
        tick();
        wait_xfers(24, 80);
        chk("full_ovf_post", ovf_o, 0);
        chk("full_w1_b0", got_b[4], 8'hC0);
        chk("full_last_b0", got_b[20], 8'h5A);
        chk("full_last_b3", got_b[23], 8'h5D);
        chk("full_last_addr", got_a[20], 4'hF);
        repeat (4) tick();

        // ---- overflow: 6 strobes while serializer is stalled ----
        clear_log();
        spi_byte_rdy_i = 1'b0;
        strobe(4'h1, 32'h50515253);
        wait_vld(10);
        for (int j = 0; j <= 6; j++) begin
            reg_rd_en_i   = (j < 6);
            reg_rd_addr_i = 4'(j);
            reg_rd_data_i = (j > 0) ? dovf(j - 1) : 32'h0;
            tick();
        end
        tick();
        chk("ovf_set", ovf_o, 1);
        spi_byte_rdy_i = 1'b1;
        wait_xfers(20, 100);
        chk("ovf_head", got_b[0], 8'h50);
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                chk("ovf_byte", got_b[4 + 4*k + b], 8'(16*(k+1) + b));
            end
            chk("ovf_addr", got_a[4 + 4*k], 4'(k));
        end
        repeat (8) tick();
        chk("ovf_dropped", got_b.size(), 20);
        chk("ovf_sticky", ovf_o, 1);

        // ---- reset mid-word ----
        clear_log();
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'h9;
        tick();
        reg_rd_en_i = 1'b1; reg_rd_addr_i = 4'h6; reg_rd_data_i = 32'hCAFEF00D;
        tick();
        reg_rd_en_i = 1'b0; reg_rd_data_i = 32'h12345678;
        wait_xfers(1, 20);
        sz = got_b.size();
        spi_byte_rdy_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mrst_vld", spi_byte_vld_o, 0);
        chk("mrst_data", spi_byte_data_o, 8'h00);
        chk("mrst_addr", spi_byte_addr_o, 4'h0);
        chk("mrst_ovf", ovf_o, 0);
        spi_byte_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mrst_idle_vld", spi_byte_vld_o, 0);
        end
        chk("mrst_no_stale", got_b.size(), sz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
